// File: rtl/irq_timer_bank.sv
// irq_timer_bank: NUM_CH programmable periodic/one-shot interrupt timers, one irq bit per channel.
// Latency: register access acked one cycle after request; expiry on edge N shows on irq after edge N+1.
// Backpressure: cfg_valid is held until cfg_ready; at most one access every two cycles.
// Ports: clk/reset (sync, active-high); cfg_valid/cfg_ready/cfg_we/cfg_addr/cfg_wdata/cfg_rdata
// register port; eoi clears latched channels; irq drives bits [IRQ_BASE +: NUM_CH]; wdog_bite sticky.
// Optional watchdog counter on WDOG (0x02) is built only when IRQ_TIMER_WDOG_EN is defined.
module irq_timer_bank #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 16,
   parameter int IRQ_BASE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_we,
   input  logic [7:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   input  logic [31:0] eoi,
   output logic [31:0] irq,
   output logic        wdog_bite
);

   logic              acc;
   logic              wr;
   logic [31:0]       cycle;
   logic [31:0]       rd_val;
   logic [31:0]       wdog_rd;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] oneshot;
   logic [NUM_CH-1:0] latch;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] exp_pulse;   // expiry seen this edge, channel in pulse mode
   logic [NUM_CH-1:0] exp_set;     // expiry seen this edge, channel in latched mode
   logic [NUM_CH-1:0] irq_pulse;   // second stage of the pulse path
   logic [NUM_CH-1:0] expire;
   logic [NUM_CH-1:0] ctrl_wr;
   logic [NUM_CH-1:0] per_wr;
   logic [NUM_CH-1:0] pend_clr;
   logic [NUM_CH-1:0] irq_ch;
   logic [CNT_W-1:0]  cnt    [NUM_CH];
   logic [CNT_W-1:0]  period [NUM_CH];
   logic              unused_ok;

   // An access is taken only while no ack is outstanding, which spaces accesses two cycles apart.
   assign acc = cfg_valid & ~cfg_ready;
   assign wr  = acc & cfg_we;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         expire[i]  = en[i] && (cnt[i] == period[i]);
         ctrl_wr[i] = wr && (cfg_addr == 8'(16 + 2 * i));
         per_wr[i]  = wr && (cfg_addr == 8'(17 + 2 * i));
      end
   end

   assign pend_clr = eoi[IRQ_BASE +: NUM_CH] |
                     ((wr && (cfg_addr == 8'h00)) ? cfg_wdata[NUM_CH-1:0] : '0);

   always_comb begin
      rd_val = 32'd0;
      if (cfg_addr == 8'h00)      rd_val = 32'(pending);
      else if (cfg_addr == 8'h01) rd_val = cycle;
      else if (cfg_addr == 8'h02) rd_val = wdog_rd;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_addr == 8'(16 + 2 * i)) rd_val = {29'd0, latch[i], oneshot[i], en[i]};
         if (cfg_addr == 8'(17 + 2 * i)) rd_val = 32'(period[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_ready <= 1'b0;
         cfg_rdata <= 32'd0;
         cycle     <= 32'd0;
         en        <= '0;
         oneshot   <= '0;
         latch     <= '0;
         pending   <= '0;
         exp_pulse <= '0;
         exp_set   <= '0;
         irq_pulse <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            period[i] <= '1;
         end
      end else begin
         cfg_ready <= acc;
         cfg_rdata <= acc ? rd_val : 32'd0;
         cycle     <= cycle + 32'd1;
         exp_pulse <= expire & ~latch;
         exp_set   <= expire & latch;
         irq_pulse <= exp_pulse;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ctrl_wr[i]) begin
               en[i]      <= cfg_wdata[0];
               oneshot[i] <= cfg_wdata[1];
               latch[i]   <= cfg_wdata[2];
            end else if (expire[i] && oneshot[i]) begin
               en[i] <= 1'b0;
            end
            // Counter restarts on any reprogramming, on expiry, and sits at 0 while disabled.
            if (ctrl_wr[i] || per_wr[i] || expire[i] || !en[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + CNT_W'(1);
            if (per_wr[i])
               period[i] <= cfg_wdata[CNT_W-1:0];
            // Dropping LATCH wipes the pending bit; otherwise a registered expiry beats a clear.
            // exp_set is re-qualified by latch so an expiry racing a LATCH-clearing write is dropped.
            if (ctrl_wr[i] && !cfg_wdata[2])
               pending[i] <= 1'b0;
            else
               pending[i] <= (pending[i] & ~pend_clr[i]) | (exp_set[i] & latch[i]);
         end
      end
   end

   assign irq_ch = irq_pulse | pending;
   assign irq    = 32'(irq_ch) << IRQ_BASE;

`ifdef IRQ_TIMER_WDOG_EN
   logic [31:0] wdog;
   logic        wdog_wr;

   assign wdog_wr = wr && (cfg_addr == 8'h02);

   // A write on the same edge as the 1->0 step reloads the counter and suppresses the bite.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog      <= 32'd0;
         wdog_bite <= 1'b0;
      end else if (wdog_wr) begin
         wdog <= cfg_wdata;
      end else if (wdog != 32'd0) begin
         wdog <= wdog - 32'd1;
         if (wdog == 32'd1) wdog_bite <= 1'b1;
      end
   end

   assign wdog_rd = wdog;
`else
   assign wdog_rd   = 32'd0;
   assign wdog_bite = 1'b0;
`endif

   // Write-data and eoi bits outside the mapped fields are intentionally ignored.
   assign unused_ok = ^{cfg_wdata, eoi};

endmodule

// File: tb/tb_irq_timer_bank.sv
// tb_irq_timer_bank: table-driven register checks plus timed sequences for irq_timer_bank.
// Reads are scoreboarded: expected data queued at request, compared when cfg_ready appears.
// Build with or without IRQ_TIMER_WDOG_EN; the watchdog section follows the macro.
module tb_irq_timer_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_we;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic [31:0] eoi;
   logic [31:0] irq;
   logic        wdog_bite;

   int checks = 0;
   int errors = 0;

   logic        sb_chk_q [$];
   logic [31:0] sb_exp_q [$];
   string       sb_nm_q  [$];
   logic        sb_bypass = 1'b0;
   logic        sb_c;
   logic [31:0] sb_e;
   string       sb_n;

   logic mon_en = 1'b0;
   int   irq4_drops = 0;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   irq_timer_bank #(.NUM_CH(2), .CNT_W(16), .IRQ_BASE(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .eoi       (eoi),
      .irq       (irq),
      .wdog_bite (wdog_bite)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: one queue entry per issued access, popped on each ack.
   always @(negedge clk) begin
      if (cfg_ready === 1'b1 && !sb_bypass) begin
         if (sb_exp_q.size() == 0) begin
            chk("sb_unexpected_ack", 32'(cfg_ready), 32'd0);
         end else begin
            sb_c = sb_chk_q.pop_front();
            sb_e = sb_exp_q.pop_front();
            sb_n = sb_nm_q.pop_front();
            if (sb_c) chk(sb_n, cfg_rdata, sb_e);
         end
      end
      if (mon_en && irq[4] !== 1'b1) irq4_drops++;
   end

   task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic c, input logic [31:0] e, input string nm);
      int n;
      @(negedge clk);
      sb_chk_q.push_back(c);
      sb_exp_q.push_back(e);
      sb_nm_q.push_back(nm);
      cfg_valid = 1'b1;
      cfg_we    = we;
      cfg_addr  = a;
      cfg_wdata = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cfg_ready !== 1'b1 && n < 8);
      cfg_valid = 1'b0;
      cfg_we    = 1'b0;
      if (cfg_ready !== 1'b1) begin
         chk({"ack_", nm}, 32'(cfg_ready), 32'd1);
         void'(sb_chk_q.pop_back());
         void'(sb_exp_q.pop_back());
         void'(sb_nm_q.pop_back());
      end
   endtask

   task automatic wait_irq(input int b, input int maxc, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (irq[b] !== 1'b1 && k < maxc);
      if (irq[b] !== 1'b1) k = -1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k, cnt4, cnt5, k5, first4, last4, bad;
      logic [31:0] r0, r1;

      tbl[0]  = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0};
      tbl[1]  = '{1'b0, 8'h10, 32'h0,        1'b1, 32'h0};
      tbl[2]  = '{1'b0, 8'h11, 32'h0,        1'b1, 32'h0000FFFF};
      tbl[3]  = '{1'b0, 8'h12, 32'h0,        1'b1, 32'h0};
      tbl[4]  = '{1'b0, 8'h13, 32'h0,        1'b1, 32'h0000FFFF};
      tbl[5]  = '{1'b0, 8'h14, 32'h0,        1'b1, 32'h0};
      tbl[6]  = '{1'b0, 8'h15, 32'h0,        1'b1, 32'h0};
      tbl[7]  = '{1'b0, 8'h02, 32'h0,        1'b1, 32'h0};
      tbl[8]  = '{1'b0, 8'h30, 32'h0,        1'b1, 32'h0};
      tbl[9]  = '{1'b1, 8'h30, 32'hFFFFFFFF, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 8'h30, 32'h0,        1'b1, 32'h0};
      tbl[11] = '{1'b1, 8'h13, 32'h00012345, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 8'h13, 32'h0,        1'b1, 32'h00002345};
      tbl[13] = '{1'b1, 8'h12, 32'h00000006, 1'b0, 32'h0};
      tbl[14] = '{1'b0, 8'h12, 32'h0,        1'b1, 32'h00000006};
      tbl[15] = '{1'b1, 8'h12, 32'hFFFFFFF8, 1'b0, 32'h0};
      tbl[16] = '{1'b0, 8'h12, 32'h0,        1'b1, 32'h0};
      tbl[17] = '{1'b1, 8'h13, 32'h0000FFFF, 1'b0, 32'h0};
      tbl[18] = '{1'b1, 8'h00, 32'hFFFFFFFF, 1'b0, 32'h0};
      tbl[19] = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0};

      reset = 1'b1; cfg_valid = 1'b0; cfg_we = 1'b0;
      cfg_addr = 8'h0; cfg_wdata = 32'h0; eoi = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_irq",   irq, 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_rdata", cfg_rdata, 32'h0);
      chk("rst_bite",  32'(wdog_bite), 32'd0);
      reset = 1'b0;

      // Register map, reset values, truncation, unmapped space
      for (int i = 0; i < NV; i++)
         xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].chk, tbl[i].exp,
              $sformatf("tbl%0d_addr%02h", i, tbl[i].addr));

      // Held read of CYCLE: ack every other cycle, data 2 apart, rdata idle at 0
      @(negedge clk);
      sb_bypass = 1'b1;
      cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h01;
      chk("hs_ready_c0", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      chk("hs_ready_c1", 32'(cfg_ready), 32'd1);
      r0 = cfg_rdata;
      @(negedge clk);
      chk("hs_ready_c2", 32'(cfg_ready), 32'd0);
      chk("hs_rdata_idle", cfg_rdata, 32'h0);
      @(negedge clk);
      chk("hs_ready_c3", 32'(cfg_ready), 32'd1);
      r1 = cfg_rdata;
      cfg_valid = 1'b0;
      chk("hs_cycle_delta", r1 - r0, 32'd2);
      @(negedge clk);
      sb_bypass = 1'b0;

      // Latched mode with end-of-interrupt
      xfer(1'b1, 8'h11, 32'd9, 1'b0, 32'h0, "lat_per");
      xfer(1'b1, 8'h10, 32'd5, 1'b0, 32'h0, "lat_ctrl");
      wait_irq(4, 40, k);
      chk("lat_rise", k, 32'd11);
      eoi = 32'h10;
      @(negedge clk);
      eoi = 32'h0;
      chk("lat_eoi_low", 32'(irq[4]), 32'd0);
      wait_irq(4, 40, k);
      chk("lat_rerise", k, 32'd9);
      xfer(1'b1, 8'h10, 32'd0, 1'b0, 32'h0, "lat_off_wr");
      chk("lat_off", irq, 32'h0);

      // Expiry every cycle against repeated W1C: set wins
      xfer(1'b1, 8'h11, 32'd0, 1'b0, 32'h0, "sw_per");
      xfer(1'b1, 8'h10, 32'd5, 1'b0, 32'h0, "sw_ctrl");
      repeat (3) @(negedge clk);
      chk("sw_irq_up", 32'(irq[4]), 32'd1);
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         xfer(1'b1, 8'h00, 32'h1, 1'b0, 32'h0, "sw_w1c");
         xfer(1'b0, 8'h00, 32'h0, 1'b1, 32'h1, $sformatf("sw_pending%0d", i));
      end
      mon_en = 1'b0;
      chk("sw_irq_drops", irq4_drops, 32'd0);
      xfer(1'b1, 8'h10, 32'd0, 1'b0, 32'h0, "sw_off_wr");
      chk("sw_off", irq, 32'h0);

      // One-shot on channel 1
      xfer(1'b1, 8'h13, 32'd3, 1'b0, 32'h0, "os_per");
      xfer(1'b1, 8'h12, 32'd3, 1'b0, 32'h0, "os_ctrl");
      cnt5 = 0; k5 = -1; bad = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (irq[5] === 1'b1) begin cnt5++; k5 = i; end
         if ((irq & ~32'h20) !== 32'h0) bad++;
      end
      chk("os_pulses", cnt5, 32'd1);
      chk("os_pulse_at", k5, 32'd5);
      chk("os_other_bits", bad, 32'd0);
      xfer(1'b0, 8'h12, 32'h0, 1'b1, 32'h2, "os_ctrl_rd");

`ifdef IRQ_TIMER_WDOG_EN
      // Periodic rewrite keeps the watchdog quiet
      for (int i = 0; i < 5; i++) begin
         xfer(1'b1, 8'h02, 32'd20, 1'b0, 32'h0, "wd_kick");
         repeat (13) @(negedge clk);
      end
      chk("wd_no_bite", 32'(wdog_bite), 32'd0);
      xfer(1'b1, 8'h02, 32'd20, 1'b0, 32'h0, "wd_arm");
      xfer(1'b0, 8'h02, 32'h0, 1'b1, 32'd19, "wd_read");
      k = 2;
      while (wdog_bite !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("wd_bite_at", k, 32'd20);
`else
      xfer(1'b1, 8'h02, 32'd20, 1'b0, 32'h0, "wd_wr");
      xfer(1'b0, 8'h02, 32'h0, 1'b1, 32'h0, "wd_read_zero");
      repeat (30) @(negedge clk);
      chk("wd_tied_low", 32'(wdog_bite), 32'd0);
`endif

      // Reset in the wait cycle of an access
      xfer(1'b1, 8'h11, 32'd2, 1'b0, 32'h0, "rm_per");
      xfer(1'b1, 8'h10, 32'd5, 1'b0, 32'h0, "rm_ctrl");
      repeat (5) @(negedge clk);
      chk("rm_pre_irq", 32'(irq[4]), 32'd1);
      @(negedge clk);
      sb_bypass = 1'b1;
      cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h01;
      reset = 1'b1;
      @(negedge clk);
      chk("rm_ready", 32'(cfg_ready), 32'd0);
      chk("rm_irq",   irq, 32'h0);
      chk("rm_rdata", cfg_rdata, 32'h0);
      chk("rm_bite",  32'(wdog_bite), 32'd0);
      reset = 1'b0;
      cfg_valid = 1'b0;
      @(negedge clk);
      sb_bypass = 1'b0;
      xfer(1'b0, 8'h01, 32'h0, 1'b1, 32'd2, "rm_cycle");
      xfer(1'b0, 8'h10, 32'h0, 1'b1, 32'h0, "rm_ctrl0");

      // Legacy taps: 2^13 and 2^16 periods
      xfer(1'b1, 8'h11, 32'd8191,  1'b0, 32'h0, "leg_per0");
      xfer(1'b1, 8'h13, 32'd65535, 1'b0, 32'h0, "leg_per1");
      xfer(1'b1, 8'h10, 32'd1,     1'b0, 32'h0, "leg_ctrl0");
      xfer(1'b1, 8'h12, 32'd1,     1'b0, 32'h0, "leg_ctrl1");
      cnt4 = 0; cnt5 = 0; k5 = -1; first4 = -1; last4 = -1; bad = 0;
      for (int i = 1; i <= 65545; i++) begin
         @(negedge clk);
         if (irq[4] === 1'b1) begin
            cnt4++;
            if (first4 < 0) first4 = i;
            if (last4 >= 0 && i - last4 != 8192) bad++;
            last4 = i;
         end
         if (irq[5] === 1'b1) begin cnt5++; k5 = i; end
         if ((irq & ~32'h30) !== 32'h0) bad++;
      end
      chk("leg_first4", first4, 32'd8191);
      chk("leg_count4", cnt4, 32'd8);
      chk("leg_count5", cnt5, 32'd1);
      chk("leg_at5",    k5, 32'd65537);
      chk("leg_bad",    bad, 32'd0);

      @(negedge clk);
      chk("sb_leftover", 32'(sb_exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
